// File: rtl/cnt_int_timer_pkg.sv
// Shared definitions for the counter-interrupt timer block.
//   NUM_CNT_CH  number of programmable down-counter channels
//   StIdle/StService  service FSM encoding (1 bit, legacy-compatible)
//   CH0/CH1     channel identifiers as carried on int_cause / cnt_int_sel
//   pick_cause  fixed-priority pick of the channel to service (ch0 first)
package timer_pkg;

  localparam int unsigned NUM_CNT_CH = 2;

  localparam logic StIdle    = 1'b0;
  localparam logic StService = 1'b1;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Caller guarantees at least one bit of pend is set.
  function automatic logic pick_cause(input logic [NUM_CNT_CH-1:0] pend);
    return pend[0] ? CH0 : CH1;
  endfunction

endpackage

// File: rtl/cnt_int_timer_if.sv
// Signal bundle between the D-stage controller and the counter-interrupt timer.
//   controller -> timer : stallD, cnt_int, cnt_int_sel, cnt_int_disable, period_D, rti
//   timer -> controller : int_en1, int_cause, in_service, pending, overrun
// modport master is the controller side, modport slave is the timer side.
interface cnt_int_timer_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic                                stallD;
  logic                                cnt_int;
  logic                                cnt_int_sel;
  logic                                cnt_int_disable;
  logic [CNT_W-1:0]                    period_D;
  logic                                rti;
  logic                                int_en1;
  logic                                int_cause;
  logic                                in_service;
  logic [timer_pkg::NUM_CNT_CH-1:0]    pending;
  logic [timer_pkg::NUM_CNT_CH-1:0]    overrun;

  modport master (
    output stallD, cnt_int, cnt_int_sel, cnt_int_disable, period_D, rti,
    input  int_en1, int_cause, in_service, pending, overrun
  );

  modport slave (
    input  stallD, cnt_int, cnt_int_sel, cnt_int_disable, period_D, rti,
    output int_en1, int_cause, in_service, pending, overrun
  );

endinterface

// File: rtl/cnt_int_channel.sv
// One programmable periodic down-counter channel.
//   clk, reset  core clock, asynchronous active-high reset
//   tick        prescaler tick; the counter only moves on ticks
//   prog        load period/count from period_in (period 0 leaves the channel disabled)
//   dis         disable the channel, keeping period and count
//   period_in   period operand for prog
//   expire      combinational: this tick reloads the counter (the channel fired)
// prog/dis take precedence over a coincident expiry, so an instruction that
// lands on the expiry cycle suppresses that expiry.
module cnt_int_channel #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             prog,
  input  logic             dis,
  input  logic [CNT_W-1:0] period_in,
  output logic             expire
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             en_q, en_d;

  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    expire   = 1'b0;
    if (prog) begin
      period_d = period_in;
      count_d  = period_in;
      en_d     = (period_in != '0);
    end else if (dis) begin
      en_d = 1'b0;
    end else if (tick && en_q) begin
      // An enabled channel always has count >= 1, so the decrement never wraps.
      if (count_q == CNT_W'(1)) begin
        count_d = period_q;
        expire  = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      en_q     <= en_d;
    end
  end

endmodule

// File: rtl/cnt_int_timer.sv
// Counter-interrupt responder sitting beside the D-stage controller.
// Two periodic down-counters raise pending bits; a one-bit service FSM takes
// one pending interrupt at a time (ch0 priority), pulsing int_en1 for exactly
// one cycle, and holds it in service until rti retires it.
//   clk, reset  core clock, asynchronous active-high reset
//   bus         cnt_int_timer_if.slave (instruction inputs, interrupt outputs)
// Parameters:
//   CNT_W     counter/period width
//   PRESCALE  core clocks per counter tick (>= 1)
module cnt_int_timer
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset,
  cnt_int_timer_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PW'(PRESCALE - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Instruction decode; nothing acts while D is stalled.
  logic                  act;
  logic [NUM_CNT_CH-1:0] ch_prog;
  logic [NUM_CNT_CH-1:0] ch_dis;
  logic [NUM_CNT_CH-1:0] ch_expire;

  assign act = bus.cnt_int & ~bus.stallD;

  for (genvar g = 0; g < NUM_CNT_CH; g++) begin : g_ch
    assign ch_prog[g] = act & ~bus.cnt_int_disable & (bus.cnt_int_sel == 1'(g));
    assign ch_dis[g]  = act &  bus.cnt_int_disable & (bus.cnt_int_sel == 1'(g));

    cnt_int_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .prog      (ch_prog[g]),
      .dis       (ch_dis[g]),
      .period_in (bus.period_D),
      .expire    (ch_expire[g])
    );
  end

  // Service FSM, pending and overrun tracking
  logic                  state_q, state_d;
  logic                  cause_q, cause_d;
  logic [NUM_CNT_CH-1:0] pending_q, pending_d;
  logic [NUM_CNT_CH-1:0] overrun_q, overrun_d;
  logic                  take;

  assign take = (state_q == StIdle) && (|pending_q) && !bus.stallD && !bus.rti;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d            = StService;
          cause_d            = pick_cause(pending_q);
          pending_d[cause_d] = 1'b0;
        end
      end
      StService: begin
        if (bus.rti && !bus.stallD) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Applied after the take: an expiry on the channel being taken this cycle
    // is a fresh pending, not an overrun.
    for (int i = 0; i < NUM_CNT_CH; i++) begin
      if (ch_prog[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end else if (ch_dis[i]) begin
        pending_d[i] = 1'b0;
      end else if (ch_expire[i]) begin
        if (pending_d[i]) begin
          overrun_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cause_q   <= CH0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.int_en1    = take;
  assign bus.int_cause  = cause_q;
  assign bus.in_service = (state_q == StService);
  assign bus.pending    = pending_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_cnt_int_timer.sv
// Bench for cnt_int_timer (CNT_W = 32, PRESCALE = 1). Expected interrupt takes
// (cycle, cause) are queued when stimulus is driven; a negedge monitor pops and
// compares them whenever int_en1 is seen. Scenario tasks add direct checks.
module tb_cnt_int_timer;

  typedef struct {
    int   cyc;
    logic cause;
  } take_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  take_t exp_q[$];
  take_t e;
  logic  cause_chk = 1'b0;
  logic  chk_cause = 1'b0;

  cnt_int_timer_if #(.CNT_W(32)) tif ();

  cnt_int_timer #(
    .CNT_W    (32),
    .PRESCALE (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      cause_chk = 1'b0;
    end else begin
      if (cause_chk) begin
        checks++;
        if (tif.int_cause !== chk_cause || tif.in_service !== 1'b1) begin
          errors++;
          $display("FAIL take_cause cyc=%0d got cause=%b in_service=%b, want cause=%b in_service=1",
                   cyc, tif.int_cause, tif.in_service, chk_cause);
        end
        cause_chk = 1'b0;
      end
      if (tif.int_en1 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_take cyc=%0d got int_en1=1, want 0 (pending=%b)",
                   cyc, tif.pending);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc) begin
            errors++;
            $display("FAIL take_cycle got cyc=%0d, want cyc=%0d", cyc, e.cyc);
          end
          chk_cause = e.cause;
          cause_chk = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic push_take(input int c, input logic cause);
    take_t t;
    t.cyc   = c;
    t.cause = cause;
    exp_q.push_back(t);
  endtask

  task automatic clear_inputs();
    tif.stallD          = 1'b0;
    tif.cnt_int         = 1'b0;
    tif.cnt_int_sel     = 1'b0;
    tif.cnt_int_disable = 1'b0;
    tif.period_D        = '0;
    tif.rti             = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic prog_ch(input logic sel, input logic [31:0] period);
    tif.cnt_int = 1'b1; tif.cnt_int_sel = sel; tif.cnt_int_disable = 1'b0;
    tif.period_D = period;
    step(1);
    tif.cnt_int = 1'b0;
  endtask

  task automatic disable_ch(input logic sel);
    tif.cnt_int = 1'b1; tif.cnt_int_sel = sel; tif.cnt_int_disable = 1'b1;
    step(1);
    tif.cnt_int = 1'b0; tif.cnt_int_disable = 1'b0;
  endtask

  task automatic pulse_rti();
    tif.rti = 1'b1;
    step(1);
    tif.rti = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tif.int_en1 !== 1'b0) begin
      errors++; $display("FAIL reset_int_en1 got %b want 0", tif.int_en1);
    end
    checks++;
    if (tif.in_service !== 1'b0) begin
      errors++; $display("FAIL reset_in_service got %b want 0", tif.in_service);
    end
    checks++;
    if (tif.int_cause !== 1'b0) begin
      errors++; $display("FAIL reset_int_cause got %b want 0", tif.int_cause);
    end
    checks++;
    if (tif.pending !== 2'b00) begin
      errors++; $display("FAIL reset_pending got %b want 00", tif.pending);
    end
    checks++;
    if (tif.overrun !== 2'b00) begin
      errors++; $display("FAIL reset_overrun got %b want 00", tif.overrun);
    end
    step(10);
  endtask

  task automatic test_single();
    int c;
    do_reset();
    c = cyc;
    push_take(c + 6, 1'b0);
    prog_ch(1'b0, 32'd5);
    goto_cyc(c + 8);
    checks++;
    if (tif.in_service !== 1'b1 || tif.int_cause !== 1'b0) begin
      errors++;
      $display("FAIL single_service got in_service=%b cause=%b want 1/0",
               tif.in_service, tif.int_cause);
    end
    pulse_rti();
    push_take(c + 11, 1'b0);
    goto_cyc(c + 13);
    pulse_rti();
    disable_ch(1'b0);
    goto_cyc(c + 20);
    checks++;
    if (tif.in_service !== 1'b0 || tif.pending !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got in_service=%b pending=%b want 0/00",
               tif.in_service, tif.pending);
    end
  endtask

  task automatic test_both();
    int c;
    do_reset();
    c = cyc;
    push_take(c + 5, 1'b0);
    prog_ch(1'b0, 32'd4);
    prog_ch(1'b1, 32'd4);
    goto_cyc(c + 6);
    checks++;
    if (tif.pending !== 2'b10 || tif.in_service !== 1'b1) begin
      errors++;
      $display("FAIL both_pending got pending=%b in_service=%b want 10/1",
               tif.pending, tif.in_service);
    end
    push_take(c + 7, 1'b1);
    pulse_rti();
    disable_ch(1'b0);
    disable_ch(1'b1);
    pulse_rti();
    checks++;
    if (tif.pending !== 2'b00 || tif.in_service !== 1'b0) begin
      errors++;
      $display("FAIL both_done got pending=%b in_service=%b want 00/0",
               tif.pending, tif.in_service);
    end
    step(6);
  endtask

  task automatic test_overrun();
    int c;
    do_reset();
    c = cyc;
    push_take(c + 3, 1'b0);
    prog_ch(1'b0, 32'd2);
    goto_cyc(c + 3);
    disable_ch(1'b0);
    prog_ch(1'b1, 32'd3);
    goto_cyc(c + 8);
    checks++;
    if (tif.pending !== 2'b10 || tif.overrun !== 2'b00) begin
      errors++;
      $display("FAIL ovr_first got pending=%b overrun=%b want 10/00", tif.pending, tif.overrun);
    end
    goto_cyc(c + 11);
    checks++;
    if (tif.overrun !== 2'b10 || tif.pending !== 2'b10 || tif.in_service !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second got overrun=%b pending=%b in_service=%b want 10/10/1",
               tif.overrun, tif.pending, tif.in_service);
    end
    goto_cyc(c + 12);
    push_take(c + 13, 1'b1);
    pulse_rti();
    disable_ch(1'b1);
    goto_cyc(c + 15);
    checks++;
    if (tif.overrun !== 2'b10 || tif.pending !== 2'b00 || tif.in_service !== 1'b1) begin
      errors++;
      $display("FAIL ovr_taken got overrun=%b pending=%b in_service=%b want 10/00/1",
               tif.overrun, tif.pending, tif.in_service);
    end
    pulse_rti();
    checks++;
    if (tif.overrun !== 2'b10 || tif.in_service !== 1'b0) begin
      errors++;
      $display("FAIL ovr_sticky got overrun=%b in_service=%b want 10/0",
               tif.overrun, tif.in_service);
    end
    prog_ch(1'b1, 32'd0);
    checks++;
    if (tif.overrun !== 2'b00) begin
      errors++; $display("FAIL ovr_clear got overrun=%b want 00", tif.overrun);
    end
    step(5);
  endtask

  task automatic test_stall();
    int c;
    do_reset();
    c = cyc;
    push_take(c + 11, 1'b0);
    prog_ch(1'b0, 32'd6);
    goto_cyc(c + 7);
    tif.stallD = 1'b1;
    goto_cyc(c + 9);
    checks++;
    if (tif.int_en1 !== 1'b0 || tif.pending !== 2'b01) begin
      errors++;
      $display("FAIL stall_hold got int_en1=%b pending=%b want 0/01", tif.int_en1, tif.pending);
    end
    goto_cyc(c + 11);
    tif.stallD = 1'b0;
    goto_cyc(c + 12);
    push_take(c + 15, 1'b0);
    tif.stallD = 1'b1;
    tif.rti    = 1'b1;
    goto_cyc(c + 14);
    checks++;
    if (tif.in_service !== 1'b1) begin
      errors++; $display("FAIL stall_rti got in_service=%b want 1", tif.in_service);
    end
    tif.stallD = 1'b0;
    goto_cyc(c + 15);
    tif.rti = 1'b0;
    disable_ch(1'b0);
    checks++;
    if (tif.pending !== 2'b00 || tif.in_service !== 1'b1) begin
      errors++;
      $display("FAIL stall_retake got pending=%b in_service=%b want 00/1",
               tif.pending, tif.in_service);
    end
    step(4);
  endtask

  task automatic test_reprogram();
    int c;
    do_reset();
    c = cyc;
    prog_ch(1'b0, 32'd3);
    goto_cyc(c + 3);
    prog_ch(1'b0, 32'd2);
    checks++;
    if (tif.pending !== 2'b00) begin
      errors++; $display("FAIL reprog_collide got pending=%b want 00", tif.pending);
    end
    push_take(c + 6, 1'b0);
    goto_cyc(c + 7);
    tif.rti = 1'b1;
    prog_ch(1'b0, 32'd0);
    tif.rti = 1'b0;
    goto_cyc(c + 18);
    checks++;
    if (tif.pending !== 2'b00 || tif.in_service !== 1'b0) begin
      errors++;
      $display("FAIL reprog_zero got pending=%b in_service=%b want 00/0",
               tif.pending, tif.in_service);
    end
  endtask

  task automatic test_reset_service();
    int c;
    do_reset();
    c = cyc;
    push_take(c + 3, 1'b0);
    prog_ch(1'b0, 32'd2);
    prog_ch(1'b1, 32'd3);
    goto_cyc(c + 5);
    checks++;
    if (tif.pending !== 2'b11 || tif.in_service !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got pending=%b in_service=%b want 11/1", tif.pending, tif.in_service);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tif.pending !== 2'b00 || tif.in_service !== 1'b0 || tif.int_en1 !== 1'b0 ||
        tif.overrun !== 2'b00 || tif.int_cause !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got pending=%b in_service=%b int_en1=%b overrun=%b cause=%b want 0s",
               tif.pending, tif.in_service, tif.int_en1, tif.overrun, tif.int_cause);
    end
    step(2);
    reset = 1'b0;
    step(12);
    checks++;
    if (tif.pending !== 2'b00 || tif.in_service !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got pending=%b in_service=%b want 00/0",
               tif.pending, tif.in_service);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_both();
    test_overrun();
    test_stall();
    test_reprogram();
    test_reset_service();
    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_takes got %0d outstanding, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
